// File: rtl/qual_pkg.sv
// Shared types and constants for the qualified-word scheduler.
// The state codes are fixed so that they match older waveform decoders.
package qual_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      ST_COLLECT = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_FEED    = 3'd2,
      ST_WAIT    = 3'd3,
      ST_EMIT    = 3'd4
   } qual_state_t;

endpackage

// File: rtl/qual_sat_cnt.sv
// Saturating up-counter; it holds at all-ones instead of wrapping.
module qual_sat_cnt
   import qual_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

   // count one event per cycle and stop at the maximum value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= {W{1'b0}};
      end else if (inc && (count != MAX_VAL)) begin
         count <= count + W'(1'b1);
      end
   end

endmodule

// File: rtl/qual_sched.sv
// Collects one engine word of bytes, replays it into the statistics engine,
// and forwards the engine result only when every window flag qualifies it.
module qual_sched
   import qual_pkg::*;
#(
   parameter int WORD_SIZE = 256,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [7:0]           s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 sc_rst_n,
   output logic [7:0]           sc_data,
   input  logic                 sc_valid_data,
   input  logic                 sc_v1_valid,
   input  logic                 sc_vcs_valid,
   input  logic                 sc_l0_valid,
   input  logic                 sc_l1_valid,
   input  logic [WORD_SIZE-1:0] sc_word,
   output logic [WORD_SIZE-1:0] m_word,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [CNT_W-1:0]     pass_cnt,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic                 timeout_err,
   output logic                 busy
);

   localparam int NB    = WORD_SIZE / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB - 1);
   localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT - 1);

   qual_state_t          state_r;
   qual_state_t          state_nxt_s;
   logic [IDX_W-1:0]     idx_r;
   logic [IDX_W-1:0]     idx_nxt_s;
   logic [TMR_W-1:0]     wait_cnt_r;
   logic [TMR_W-1:0]     wait_cnt_nxt_s;
   logic [WORD_SIZE-1:0] buf_r;
   logic                 s_hs_s;
   logic                 all_ok_s;
   logic                 pass_s;
   logic                 fail_s;
   logic                 timeout_s;

   // s_ready is only ever high in COLLECT, so it alone qualifies a byte transfer
   assign s_hs_s   = s_valid & s_ready;
   assign all_ok_s = sc_v1_valid & sc_vcs_valid & sc_l0_valid & sc_l1_valid;

   // next-state, byte index and wait-timer decisions
   always_comb begin
      state_nxt_s    = state_r;
      idx_nxt_s      = idx_r;
      wait_cnt_nxt_s = wait_cnt_r;
      pass_s         = 1'b0;
      fail_s         = 1'b0;
      timeout_s      = 1'b0;
      case (state_r)
         ST_COLLECT: begin
            if (s_hs_s) begin
               if (idx_r == LAST_IDX) begin
                  state_nxt_s = ST_CLEAR;
                  idx_nxt_s   = {IDX_W{1'b0}};
               end else begin
                  idx_nxt_s = idx_r + IDX_W'(1'b1);
               end
            end else begin
               idx_nxt_s = idx_r;
            end
         end
         ST_CLEAR: begin
            state_nxt_s = ST_FEED;
            idx_nxt_s   = {IDX_W{1'b0}};
         end
         ST_FEED: begin
            if (idx_r == LAST_IDX) begin
               state_nxt_s    = ST_WAIT;
               idx_nxt_s      = {IDX_W{1'b0}};
               wait_cnt_nxt_s = {TMR_W{1'b0}};
            end else begin
               idx_nxt_s = idx_r + IDX_W'(1'b1);
            end
         end
         ST_WAIT: begin
            // a result in the cycle that would bring the timer to TIMEOUT still wins
            if (sc_valid_data) begin
               if (all_ok_s) begin
                  pass_s      = 1'b1;
                  state_nxt_s = ST_EMIT;
               end else begin
                  fail_s      = 1'b1;
                  state_nxt_s = ST_COLLECT;
               end
            end else if (wait_cnt_r == LAST_TICK) begin
               timeout_s   = 1'b1;
               fail_s      = 1'b1;
               state_nxt_s = ST_COLLECT;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + TMR_W'(1'b1);
            end
         end
         ST_EMIT: begin
            if (m_valid && m_ready) begin
               state_nxt_s = ST_COLLECT;
            end else begin
               state_nxt_s = ST_EMIT;
            end
         end
         default: begin
            state_nxt_s = ST_COLLECT;
            idx_nxt_s   = {IDX_W{1'b0}};
         end
      endcase
   end

   // state, byte buffer and all registered outputs, decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_COLLECT;
         idx_r       <= {IDX_W{1'b0}};
         wait_cnt_r  <= {TMR_W{1'b0}};
         buf_r       <= {WORD_SIZE{1'b0}};
         s_ready     <= 1'b0;
         sc_rst_n    <= 1'b0;
         sc_data     <= 8'h00;
         m_valid     <= 1'b0;
         m_word      <= {WORD_SIZE{1'b0}};
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         idx_r       <= idx_nxt_s;
         wait_cnt_r  <= wait_cnt_nxt_s;
         if (s_hs_s) begin
            buf_r[{idx_r, 3'b000} +: 8] <= s_data;
         end
         s_ready     <= (state_nxt_s == ST_COLLECT);
         sc_rst_n    <= (state_nxt_s != ST_CLEAR);
         sc_data     <= (state_nxt_s == ST_FEED) ? buf_r[{idx_nxt_s, 3'b000} +: 8] : 8'h00;
         m_valid     <= (state_nxt_s == ST_EMIT);
         if (pass_s) begin
            m_word <= sc_word;
         end
         timeout_err <= timeout_s;
         busy        <= (state_nxt_s != ST_COLLECT);
      end
   end

   qual_sat_cnt #(.W(CNT_W)) u_pass_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pass_s),
      .count (pass_cnt)
   );

   qual_sat_cnt #(.W(CNT_W)) u_fail_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (fail_s),
      .count (fail_cnt)
   );

endmodule

// File: tb/tb_qual_sched.sv
// Randomized transaction-level bench for qual_sched: a word-level model of
// the collect/clear/feed/wait/emit sequence plus a behavioural engine stub.
module tb_qual_sched;
   import qual_pkg::*;

   localparam int WS = 256;
   localparam int NB = WS / 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_ready;
   logic          sc_rst_n;
   logic [7:0]    sc_data;
   logic          sc_valid_data;
   logic          sc_v1_valid;
   logic          sc_vcs_valid;
   logic          sc_l0_valid;
   logic          sc_l1_valid;
   logic [WS-1:0] sc_word;
   logic [WS-1:0] m_word;
   logic          m_valid;
   logic          m_ready;
   logic [15:0]   pass_cnt;
   logic [15:0]   fail_cnt;
   logic          timeout_err;
   logic          busy;
   logic          sat_inc;
   logic [9:0]    sat_q;

   int            checks_cnt = 0;
   int            errors_cnt = 0;
   int            exp_pass = 0;
   int            exp_fail = 0;
   logic [7:0]    cur_bytes [NB];

   always #5 clk = ~clk;

   qual_sched #(.WORD_SIZE(WS), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_data        (s_data),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .sc_rst_n      (sc_rst_n),
      .sc_data       (sc_data),
      .sc_valid_data (sc_valid_data),
      .sc_v1_valid   (sc_v1_valid),
      .sc_vcs_valid  (sc_vcs_valid),
      .sc_l0_valid   (sc_l0_valid),
      .sc_l1_valid   (sc_l1_valid),
      .sc_word       (sc_word),
      .m_word        (m_word),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .pass_cnt      (pass_cnt),
      .fail_cnt      (fail_cnt),
      .timeout_err   (timeout_err),
      .busy          (busy)
   );

   // narrow instance so saturation is reachable in a short run
   qual_sat_cnt #(.W(10)) u_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sat_inc),
      .count (sat_q)
   );

   task automatic chk_val(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WS-1:0] rnd_word();
      logic [WS-1:0] w;
      for (int i = 0; i < WS / 32; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   // engine inputs are don't-care outside WAIT, so drive garbage there
   task automatic noise();
      sc_valid_data = 1'($urandom);
      {sc_v1_valid, sc_vcs_valid, sc_l0_valid, sc_l1_valid} = 4'($urandom);
      sc_word = rnd_word();
      m_ready = 1'($urandom);
   endtask

   task automatic chk_cnts();
      chk_val("pass_cnt", pass_cnt, (exp_pass > 65535) ? 65535 : exp_pass);
      chk_val("fail_cnt", fail_cnt, (exp_fail > 65535) ? 65535 : exp_fail);
   endtask

   task automatic chk_reset_vals();
      chk_val("rst_s_ready", s_ready, 0);
      chk_val("rst_sc_rst_n", sc_rst_n, 0);
      chk_val("rst_sc_data", sc_data, 0);
      chk_val("rst_m_valid", m_valid, 0);
      chk_val("rst_m_word", m_word, 0);
      chk_val("rst_timeout", timeout_err, 0);
      chk_val("rst_busy", busy, 0);
      chk_cnts();
   endtask

   // stream NB random bytes with random gaps; returns in the CLEAR cycle
   task automatic send_word();
      int idx = 0;
      int budget = NB * 8;
      bit hs;
      for (int i = 0; i < NB; i++) cur_bytes[i] = 8'($urandom);
      while (idx < NB && budget > 0) begin
         noise();
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = s_valid ? cur_bytes[idx] : 8'($urandom);
         hs = s_valid && s_ready;
         step();
         if (hs) idx++;
         budget--;
      end
      s_valid = 1'b0;
      if (idx < NB) chk_val("collect_budget", idx, NB);
   endtask

   // one full word: engine answers in WAIT cycle d (d >= TO means never)
   task automatic run_word(input int d, input logic [3:0] flags, input int rdel);
      logic [WS-1:0] word;
      send_word();
      chk_val("clear_s_ready", s_ready, 0);
      chk_val("clear_sc_rst_n", sc_rst_n, 0);
      chk_val("clear_busy", busy, 1);
      chk_val("clear_sc_data", sc_data, 0);
      noise();
      step();
      for (int i = 0; i < NB; i++) begin
         chk_val("feed_data", sc_data, cur_bytes[i]);
         chk_val("feed_sc_rst_n", sc_rst_n, 1);
         chk_val("feed_s_ready", s_ready, 0);
         noise();
         step();
      end
      for (int j = 0; j < d; j++) begin
         chk_val("wait_sc_data", sc_data, 0);
         chk_val("wait_m_valid", m_valid, 0);
         chk_val("wait_s_ready", s_ready, 0);
         noise();
         sc_valid_data = 1'b0;
         step();
         if (j == TO - 1) begin
            exp_fail++;
            chk_val("timeout_pulse", timeout_err, 1);
            chk_val("timeout_s_ready", s_ready, 1);
            chk_val("timeout_busy", busy, 0);
            chk_val("timeout_m_valid", m_valid, 0);
            chk_cnts();
            noise();
            step();
            chk_val("timeout_one_cycle", timeout_err, 0);
            return;
         end
         chk_val("wait_no_timeout", timeout_err, 0);
      end
      word = rnd_word();
      sc_valid_data = 1'b1;
      {sc_v1_valid, sc_vcs_valid, sc_l0_valid, sc_l1_valid} = flags;
      sc_word = word;
      m_ready = 1'b0;
      step();
      chk_val("result_timeout", timeout_err, 0);
      if (flags == 4'hF) begin
         exp_pass++;
         chk_val("pass_m_valid", m_valid, 1);
         chk_val("pass_m_word", m_word, word);
         chk_val("pass_s_ready", s_ready, 0);
         chk_val("pass_busy", busy, 1);
         chk_cnts();
         for (int k = 0; k < rdel; k++) begin
            noise();
            m_ready = 1'b0;
            step();
            chk_val("hold_m_valid", m_valid, 1);
            chk_val("hold_m_word", m_word, word);
         end
         noise();
         m_ready = 1'b1;
         step();
         m_ready = 1'b0;
         chk_val("emit_m_valid_drop", m_valid, 0);
         chk_val("emit_s_ready", s_ready, 1);
         chk_val("emit_busy", busy, 0);
      end else begin
         exp_fail++;
         chk_val("fail_m_valid", m_valid, 0);
         chk_val("fail_s_ready", s_ready, 1);
         chk_val("fail_busy", busy, 0);
         chk_cnts();
      end
   endtask

   initial begin
      logic [3:0] fl;
      rst_n = 1'b0;
      s_valid = 1'b0;
      s_data = 8'h00;
      sat_inc = 1'b0;
      noise();
      #2;
      chk_reset_vals();
      chk_val("rst_sat", sat_q, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_val("pre_edge_s_ready", s_ready, 0);
      step();
      chk_val("post_rst_s_ready", s_ready, 1);
      chk_val("post_rst_sc_rst_n", sc_rst_n, 1);
      chk_val("post_rst_busy", busy, 0);

      run_word(3, 4'hF, 10);
      run_word(5, 4'b1110, 0);
      run_word(TO, 4'hF, 0);
      run_word(TO - 1, 4'hF, 2);
      run_word(0, 4'hF, 0);
      for (int n = 0; n < 20; n++) begin
         fl = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 14));
         run_word($urandom_range(0, TO + 6), fl, $urandom_range(0, 5));
      end

      // reset while FEED is on byte 10
      send_word();
      step();
      for (int i = 0; i < 10; i++) step();
      chk_val("pre_rst_feed", sc_data, cur_bytes[10]);
      rst_n = 1'b0;
      #1;
      exp_pass = 0;
      exp_fail = 0;
      chk_reset_vals();
      step();
      step();
      rst_n = 1'b1;
      chk_val("rel_s_ready", s_ready, 0);
      step();
      chk_val("rel2_s_ready", s_ready, 1);
      run_word(2, 4'hF, 1);
      run_word(4, 4'b0111, 0);

      sat_inc = 1'b1;
      repeat (500) step();
      chk_val("sat_mid", sat_q, 500);
      repeat (600) step();
      chk_val("sat_max", sat_q, 10'h3FF);
      sat_inc = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/qual_sched.md
QUAL_SCHED -- requirements
Module: qual_sched

Interface
REQ-001 Parameter WORD_SIZE, default 256: engine word width in bits; multiple of 8; NB = WORD_SIZE/8 bytes per word.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT-state cycles before the word is abandoned.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 s_data  in  8  upstream byte; s_valid  in  1; s_ready  out  1: transfer occurs when s_valid & s_ready.
REQ-006 sc_rst_n  out  1  active-low clear to the statistics engine (static_ctrl).
REQ-007 sc_data  out  8  byte driven into the engine input_data every cycle.
REQ-008 sc_valid_data, sc_v1_valid, sc_vcs_valid, sc_l0_valid, sc_l1_valid  in  1 each  engine result strobe and window flags.
REQ-009 sc_word  in  WORD_SIZE  engine output_data.
REQ-010 m_word  out  WORD_SIZE; m_valid  out  1; m_ready  in  1: qualified-word output; transfer occurs when m_valid & m_ready.
REQ-011 pass_cnt, fail_cnt  out  16 each  saturating counters; timeout_err  out  1  one-cycle pulse; busy  out  1  high in any state except COLLECT.

Function
REQ-012 FSM states: COLLECT, CLEAR, FEED, WAIT, EMIT.
REQ-013 COLLECT: s_ready=1; each accepted byte number k (0..NB-1) is stored in buffer bits [8k+7:8k]; when byte NB-1 is accepted -> CLEAR on the next cycle.
REQ-014 s_ready=0 in every state other than COLLECT; no bytes are lost or duplicated.
REQ-015 CLEAR: exactly one cycle with sc_rst_n=0 -> FEED.
REQ-016 FEED: exactly NB consecutive cycles with sc_data = buffer byte 0, 1, ..., NB-1 in order -> WAIT.
REQ-017 sc_data = 0 in all states except FEED; sc_rst_n = 1 in all states except CLEAR.
REQ-018 WAIT: the cycle counter starts at 0; the first cycle with sc_valid_data=1 ends WAIT.
REQ-019 In that cycle, if all four flags are 1 -> pass: m_word <= sc_word, pass_cnt+1, -> EMIT.
REQ-020 In that cycle, if any flag is 0 -> fail: fail_cnt+1, -> COLLECT.
REQ-021 If TIMEOUT cycles elapse in WAIT without sc_valid_data: timeout_err=1 for one cycle, fail_cnt+1, -> COLLECT.
REQ-022 sc_valid_data=1 on the same cycle the counter reaches TIMEOUT counts as a result, not a timeout.
REQ-023 EMIT: m_valid=1 and m_word is held stable until m_ready=1; on the handshake cycle -> COLLECT, and m_valid drops the next cycle.
REQ-024 m_valid=0 in all states except EMIT.
REQ-025 Counters saturate at 16'hFFFF and never wrap.
REQ-026 sc_* inputs are ignored outside WAIT.

Reset
REQ-027 While rst_n=0: state=COLLECT, byte index=0, s_ready=0, sc_rst_n=0, sc_data=0, m_valid=0, m_word=0, pass_cnt=0, fail_cnt=0, timeout_err=0, busy=0.
REQ-028 Reset asserted mid-operation discards the partial buffer and any pending m_word.
REQ-029 s_ready rises on the first clock edge after rst_n deasserts.

Structure
REQ-030 Shared package qual_pkg holds the state enum qual_state_t and the counter width constant CNT_W=16.
REQ-031 One sub-module is natural: qual_sat_cnt, a saturating counter instantiated for pass_cnt and fail_cnt; the engine itself stays outside this block.

Verification
REQ-032 Case 1: WORD_SIZE=256, 32 bytes streamed with s_valid held high -> s_ready drops after byte 31; one CLEAR cycle; 32 FEED cycles in byte order.
REQ-033 Case 2: engine model returns all flags =1 -> m_valid=1, m_word = sc_word, pass_cnt=1; m_ready held low 10 cycles -> m_word stays stable.
REQ-034 Case 3: engine returns v1_valid=0 -> fail_cnt=1, m_valid never rises, s_ready=1 on the next cycle.
REQ-035 Case 4: engine never asserts sc_valid_data, TIMEOUT=64 -> timeout_err pulses 64 cycles after WAIT entry; fail_cnt=1.
REQ-036 Case 5: rst_n pulled low during FEED byte 10 -> all outputs at reset values; the next 32 bytes form a fresh word.
REQ-037 Case 6: pass_cnt preloaded via 65537 passes -> pass_cnt = 16'hFFFF (saturates, no wrap).
